// File: rtl/versatile_fifo_mc_sync_if.sv
// versatile_fifo_mc_sync_if: write/read/flush bundle of the multi-channel FIFO; fifo_afull exists only with VERSATILE_FIFO_MC_AFULL_EN
interface versatile_fifo_mc_sync_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_BITS    = 2
);
  localparam int NCH = 2 ** CH_BITS;
  logic [NCH-1:0]        clr;
  logic [CH_BITS-1:0]    wr_ch;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic [CH_BITS-1:0]    rd_ch;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  rd_vld;
  logic [NCH-1:0]        fifo_full;
  logic [NCH-1:0]        fifo_empty;
`ifdef VERSATILE_FIFO_MC_AFULL_EN
  logic [NCH-1:0]        fifo_afull;
`endif
  modport master (
    output clr, wr_ch, wr_en, wr_dat, rd_ch, rd_en,
    input  rd_dat, rd_vld, fifo_full, fifo_empty
`ifdef VERSATILE_FIFO_MC_AFULL_EN
    , fifo_afull
`endif
  );
  modport slave (
    input  clr, wr_ch, wr_en, wr_dat, rd_ch, rd_en,
    output rd_dat, rd_vld, fifo_full, fifo_empty
`ifdef VERSATILE_FIFO_MC_AFULL_EN
    , fifo_afull
`endif
  );
endinterface

// File: rtl/versatile_fifo_mc_sync.sv
// versatile_fifo_mc_sync: N-channel single-clock FIFO bank over one shared RAM; VERSATILE_FIFO_MC_AFULL_EN adds fifo_afull
module versatile_fifo_mc_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int CH_BITS     = 2,
  parameter int ADDR_WIDTH  = 9,
  parameter int AFULL_LEVEL = 448
) (
  input logic clk,
  input logic rst,
  versatile_fifo_mc_sync_if.slave bus
);
  localparam int NCH   = 2 ** CH_BITS;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [ADDR_WIDTH:0]   wptr [NCH];
  logic [ADDR_WIDTH:0]   rptr [NCH];
  logic [DATA_WIDTH-1:0] mem  [NCH*DEPTH];
  logic [NCH-1:0]        full, empty, wr_hit, rd_hit;
  logic                  wr_acc, rd_acc;
  always_comb
    for (int i = 0; i < NCH; i++) begin
      empty[i] = wptr[i] == rptr[i];
      full[i]  = (wptr[i][ADDR_WIDTH-1:0] == rptr[i][ADDR_WIDTH-1:0]) && (wptr[i][ADDR_WIDTH] != rptr[i][ADDR_WIDTH]);
    end
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
`ifdef VERSATILE_FIFO_MC_AFULL_EN
  if (AFULL_LEVEL == 0 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("AFULL_LEVEL must be in 1..DEPTH");
  end
  logic [NCH-1:0] afull;
  always_comb
    for (int i = 0; i < NCH; i++)
      afull[i] = (wptr[i] - rptr[i]) >= (ADDR_WIDTH+1)'(AFULL_LEVEL);
  assign bus.fifo_afull = afull;
`endif
  // flags are pre-edge, so an empty channel never falls through and a full one never overwrites
  assign wr_acc = bus.wr_en & ~full[bus.wr_ch] & ~bus.clr[bus.wr_ch];
  assign rd_acc = bus.rd_en & ~empty[bus.rd_ch] & ~bus.clr[bus.rd_ch];
  assign wr_hit = wr_acc ? NCH'(1) << bus.wr_ch : '0;
  assign rd_hit = rd_acc ? NCH'(1) << bus.rd_ch : '0;
  always_ff @(posedge clk)
    for (int i = 0; i < NCH; i++)
      if (rst || bus.clr[i]) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end else begin
        if (wr_hit[i]) wptr[i] <= wptr[i] + 1'b1;
        if (rd_hit[i]) rptr[i] <= rptr[i] + 1'b1;
      end
  always_ff @(posedge clk)
    if (wr_acc && !rst) mem[{bus.wr_ch, wptr[bus.wr_ch][ADDR_WIDTH-1:0]}] <= bus.wr_dat;
  always_ff @(posedge clk)
    if (rst) begin
      bus.rd_vld <= 1'b0;
      bus.rd_dat <= '0;
    end else begin
      bus.rd_vld <= rd_acc;
      if (rd_acc) bus.rd_dat <= mem[{bus.rd_ch, rptr[bus.rd_ch][ADDR_WIDTH-1:0]}];
    end
endmodule

// File: tb/tb_versatile_fifo_mc_sync.sv
// tb_versatile_fifo_mc_sync: directed checks of the 4-channel, 512-deep, 8-bit FIFO bank
module tb_versatile_fifo_mc_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errs = 0;
  versatile_fifo_mc_sync_if #(.DATA_WIDTH(8), .CH_BITS(2)) bus ();
  versatile_fifo_mc_sync dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input logic we, input logic [1:0] wc, input logic [7:0] wd,
                      input logic re, input logic [1:0] rc, input logic [3:0] cl);
    bus.wr_en = we; bus.wr_ch = wc; bus.wr_dat = wd;
    bus.rd_en = re; bus.rd_ch = rc; bus.clr = cl;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (bus.fifo_empty !== 4'hF) begin errs++; $display("FAIL reset_empty got %h exp f", bus.fifo_empty); end
    checks++; if (bus.fifo_full !== 4'h0) begin errs++; $display("FAIL reset_full got %h exp 0", bus.fifo_full); end
    checks++; if (bus.rd_vld !== 1'b0) begin errs++; $display("FAIL reset_vld got %b exp 0", bus.rd_vld); end
    checks++; if (bus.rd_dat !== 8'h00) begin errs++; $display("FAIL reset_dat got %h exp 00", bus.rd_dat); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (bus.rd_vld !== 1'b0) begin errs++; $display("FAIL empty_read_vld got %b exp 0", bus.rd_vld); end
  endtask

  task automatic test_basic();
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    for (int i = 0; i < 3; i++) step(1, 2, exp[i], 0, 0, 0);
    checks++; if (bus.fifo_empty !== 4'b1011) begin errs++; $display("FAIL basic_empty got %b exp 1011", bus.fifo_empty); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 2, 0);
      checks++; if (bus.rd_vld !== 1'b1 || bus.rd_dat !== exp[i]) begin errs++; $display("FAIL basic_read%0d got vld=%b dat=%h exp vld=1 dat=%h", i, bus.rd_vld, bus.rd_dat, exp[i]); end
    end
    checks++; if (bus.fifo_empty !== 4'hF) begin errs++; $display("FAIL basic_end_empty got %b exp 1111", bus.fifo_empty); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 512; i++) begin
      step(1, 1, 8'(i), 0, 0, 0);
      if (i == 510) begin
        checks++; if (bus.fifo_full[1] !== 1'b0) begin errs++; $display("FAIL full_511 got %b exp 0", bus.fifo_full[1]); end
      end
    end
    checks++; if (bus.fifo_full !== 4'b0010) begin errs++; $display("FAIL full_512 got %b exp 0010", bus.fifo_full); end
    step(1, 1, 8'hEE, 0, 0, 0);
    checks++; if (bus.fifo_full !== 4'b0010) begin errs++; $display("FAIL full_drop got %b exp 0010", bus.fifo_full); end
    step(1, 1, 8'hDD, 1, 1, 0);
    checks++; if (bus.rd_vld !== 1'b1 || bus.rd_dat !== 8'h00) begin errs++; $display("FAIL full_rw got vld=%b dat=%h exp vld=1 dat=00", bus.rd_vld, bus.rd_dat); end
    checks++; if (bus.fifo_full[1] !== 1'b0) begin errs++; $display("FAIL full_rw_flag got %b exp 0", bus.fifo_full[1]); end
    for (int i = 1; i < 512; i++) begin
      step(0, 0, 0, 1, 1, 0);
      checks++; if (bus.rd_vld !== 1'b1 || bus.rd_dat !== 8'(i)) begin errs++; $display("FAIL full_read%0d got vld=%b dat=%h exp vld=1 dat=%h", i, bus.rd_vld, bus.rd_dat, 8'(i)); end
    end
    checks++; if (bus.fifo_empty !== 4'hF || bus.fifo_full !== 4'h0) begin errs++; $display("FAIL full_end got e=%b f=%b exp e=1111 f=0000", bus.fifo_empty, bus.fifo_full); end
    step(0, 0, 0, 1, 1, 0);
    checks++; if (bus.rd_vld !== 1'b0) begin errs++; $display("FAIL full_extra_read got %b exp 0", bus.rd_vld); end
    step(1, 1, 8'h77, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    checks++; if (bus.rd_vld !== 1'b1 || bus.rd_dat !== 8'h77) begin errs++; $display("FAIL wrap_read got vld=%b dat=%h exp vld=1 dat=77", bus.rd_vld, bus.rd_dat); end
  endtask

  task automatic test_same_cycle();
    step(1, 3, 8'hA5, 0, 0, 0);
    step(1, 3, 8'h5A, 1, 3, 0);
    checks++; if (bus.rd_vld !== 1'b1 || bus.rd_dat !== 8'hA5) begin errs++; $display("FAIL rw1_read got vld=%b dat=%h exp vld=1 dat=a5", bus.rd_vld, bus.rd_dat); end
    checks++; if (bus.fifo_empty[3] !== 1'b0) begin errs++; $display("FAIL rw1_fill got empty=%b exp 0", bus.fifo_empty[3]); end
    step(0, 0, 0, 1, 3, 0);
    checks++; if (bus.rd_vld !== 1'b1 || bus.rd_dat !== 8'h5A) begin errs++; $display("FAIL rw1_next got vld=%b dat=%h exp vld=1 dat=5a", bus.rd_vld, bus.rd_dat); end
    checks++; if (bus.fifo_empty[3] !== 1'b1) begin errs++; $display("FAIL rw1_empty got %b exp 1", bus.fifo_empty[3]); end
    step(1, 3, 8'hC3, 1, 3, 0);
    checks++; if (bus.rd_vld !== 1'b0 || bus.rd_dat !== 8'h5A) begin errs++; $display("FAIL rw0_reject got vld=%b dat=%h exp vld=0 dat=5a", bus.rd_vld, bus.rd_dat); end
    checks++; if (bus.fifo_empty[3] !== 1'b0) begin errs++; $display("FAIL rw0_landed got empty=%b exp 0", bus.fifo_empty[3]); end
    step(0, 0, 0, 1, 3, 0);
    checks++; if (bus.rd_vld !== 1'b1 || bus.rd_dat !== 8'hC3) begin errs++; $display("FAIL rw0_read got vld=%b dat=%h exp vld=1 dat=c3", bus.rd_vld, bus.rd_dat); end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 100; i++) step(1, 3, 8'(i * 3 + 7), 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 8'(i ^ 90), 1, 3, 0);
      checks++; if (bus.rd_vld !== 1'b1 || bus.rd_dat !== 8'(i * 3 + 7)) begin errs++; $display("FAIL il_ch3_%0d got vld=%b dat=%h exp vld=1 dat=%h", i, bus.rd_vld, bus.rd_dat, 8'(i * 3 + 7)); end
    end
    checks++; if (bus.fifo_empty !== 4'b1110) begin errs++; $display("FAIL il_mid_empty got %b exp 1110", bus.fifo_empty); end
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 1, 0, 0);
      checks++; if (bus.rd_vld !== 1'b1 || bus.rd_dat !== 8'(i ^ 90)) begin errs++; $display("FAIL il_ch0_%0d got vld=%b dat=%h exp vld=1 dat=%h", i, bus.rd_vld, bus.rd_dat, 8'(i ^ 90)); end
    end
    checks++; if (bus.fifo_empty !== 4'hF) begin errs++; $display("FAIL il_end_empty got %b exp 1111", bus.fifo_empty); end
  endtask

  task automatic test_flush();
    step(1, 0, 8'hC0, 0, 0, 0);
    step(1, 0, 8'hC1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 2, 8'(8'h90 + i), 0, 0, 0);
    step(0, 0, 0, 1, 2, 4'b0100);
    checks++; if (bus.rd_vld !== 1'b0) begin errs++; $display("FAIL flush_vld got %b exp 0", bus.rd_vld); end
    checks++; if (bus.fifo_empty !== 4'b1110) begin errs++; $display("FAIL flush_empty got %b exp 1110", bus.fifo_empty); end
    step(1, 2, 8'h99, 0, 0, 4'b0100);
    checks++; if (bus.fifo_empty[2] !== 1'b1) begin errs++; $display("FAIL flush_wr_override got %b exp 1", bus.fifo_empty[2]); end
    step(0, 0, 0, 1, 2, 0);
    checks++; if (bus.rd_vld !== 1'b0) begin errs++; $display("FAIL flush_read_after got %b exp 0", bus.rd_vld); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (bus.rd_vld !== 1'b1 || bus.rd_dat !== 8'hC0) begin errs++; $display("FAIL flush_ch0_a got vld=%b dat=%h exp vld=1 dat=c0", bus.rd_vld, bus.rd_dat); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (bus.rd_vld !== 1'b1 || bus.rd_dat !== 8'hC1) begin errs++; $display("FAIL flush_ch0_b got vld=%b dat=%h exp vld=1 dat=c1", bus.rd_vld, bus.rd_dat); end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 8'h42, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 1, 1, 0);
    rst = 1'b0;
    checks++; if (bus.rd_vld !== 1'b0 || bus.rd_dat !== 8'h00) begin errs++; $display("FAIL rst_mid got vld=%b dat=%h exp vld=0 dat=00", bus.rd_vld, bus.rd_dat); end
    checks++; if (bus.fifo_empty !== 4'hF) begin errs++; $display("FAIL rst_mid_empty got %b exp 1111", bus.fifo_empty); end
  endtask

`ifdef VERSATILE_FIFO_MC_AFULL_EN
  task automatic test_afull();
    for (int i = 0; i < 448; i++) begin
      step(1, 0, 8'(i), 0, 0, 0);
      if (i == 446) begin
        checks++; if (bus.fifo_afull !== 4'h0) begin errs++; $display("FAIL afull_447 got %b exp 0000", bus.fifo_afull); end
      end
    end
    checks++; if (bus.fifo_afull !== 4'b0001) begin errs++; $display("FAIL afull_448 got %b exp 0001", bus.fifo_afull); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (bus.fifo_afull !== 4'h0) begin errs++; $display("FAIL afull_fall got %b exp 0000", bus.fifo_afull); end
    step(0, 0, 0, 0, 0, 4'b0001);
  endtask
`endif

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr = '0;
    bus.wr_ch = '0; bus.rd_ch = '0; bus.wr_dat = '0;
    test_reset();
    test_basic();
    test_full();
    test_same_cycle();
    test_interleave();
    test_flush();
    test_reset_mid();
`ifdef VERSATILE_FIFO_MC_AFULL_EN
    test_afull();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
